// File: rtl/qdiv_seq_if.sv
// qdiv_seq_if: start/busy/done handshake and operand/result bundle for qdiv_seq
interface qdiv_seq_if #(parameter int N = 16);
  logic         i_start;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_result;
  logic         o_ovr;
  logic         o_dbz;
  modport master (output i_start, i_dividend, i_divisor, input o_busy, o_done, o_result, o_ovr, o_dbz);
  modport slave  (input i_start, i_dividend, i_divisor, output o_busy, o_done, o_result, o_ovr, o_dbz);
endinterface

// File: rtl/qdiv_seq.sv
// qdiv_seq: sequential signed QN.Q restoring divider, one quotient bit per clock; define QDIV_ROUND_EN for round-half-away-from-zero
module qdiv_seq #(
  parameter int Q = 8,
  parameter int N = 16
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  qdiv_seq_if.slave bus
);
`ifdef QDIV_ROUND_EN
  localparam int W = N + Q + 1;
`else
  localparam int W = N + Q;
`endif
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          r_state;
  logic [W-1:0]    r_dvd;
  logic [N-1:0]    r_rem;
  logic [N-1:0]    r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            r_dbz_c;
  logic            r_busy;
  logic            r_done;
  logic [N-1:0]    r_result;
  logic            r_ovr;
  logic            r_dbz;
  logic [N-1:0]    w_abs_dd;
  logic [N-1:0]    w_abs_dv;
  logic [N:0]      w_rem_sh;
  logic            w_ge;
  logic [N-1:0]    w_rem_nx;
  logic [W-1:0]    w_q;
  logic            w_sat;
  logic [N-2:0]    w_mag;
  logic [N-1:0]    w_res;
  assign w_abs_dd = bus.i_dividend[N-1] ? (~bus.i_dividend + 1'b1) : bus.i_dividend;
  assign w_abs_dv = bus.i_divisor[N-1]  ? (~bus.i_divisor  + 1'b1) : bus.i_divisor;
  assign w_rem_sh = {r_rem, r_dvd[W-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_dvs};
  assign w_rem_nx = w_ge ? N'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[N-1:0];
`ifdef QDIV_ROUND_EN
  assign w_q      = {1'b0, r_dvd[W-1:1]} + W'(r_dvd[0]);
`else
  assign w_q      = r_dvd;
`endif
  assign w_sat    = r_dbz_c | (|w_q[W-1:N-1]);
  assign w_mag    = w_sat ? {(N-1){1'b1}} : w_q[N-2:0];
  assign w_res    = r_sign ? (~{1'b0, w_mag} + 1'b1) : {1'b0, w_mag};
  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_result = r_result;
  assign bus.o_ovr    = r_ovr;
  assign bus.o_dbz    = r_dbz;
  // Control FSM with the shift/subtract datapath and registered handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_dbz_c  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovr    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.i_start) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
            r_dvd   <= {w_abs_dd, {(W-N){1'b0}}};
            r_dvs   <= w_abs_dv;
            r_rem   <= '0;
            r_cnt   <= CW'(W);
            r_sign  <= (bus.i_dividend[N-1] ^ bus.i_divisor[N-1]) & (|bus.i_dividend);
            r_dbz_c <= ~|bus.i_divisor;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          if (~|r_cnt) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_res;
            r_ovr    <= w_sat;
            r_dbz    <= r_dbz_c;
          end else begin
            r_rem <= w_rem_nx;
            r_dvd <= {r_dvd[W-2:0], w_ge};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qdiv_seq.sv
// tb_qdiv_seq: scoreboard bench for qdiv_seq with directed vectors
module tb_qdiv_seq;
  localparam int N = 16;
  localparam int Q = 8;
`ifdef QDIV_ROUND_EN
  localparam int LAT = 26;
  localparam logic [15:0] R_2DIV3 = 16'h00AB;
`else
  localparam int LAT = 25;
  localparam logic [15:0] R_2DIV3 = 16'h00AA;
`endif
  typedef struct {
    logic [15:0] res;
    logic        ovr;
    logic        dbz;
    int          cyc;
    string       nm;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];
  qdiv_seq_if #(.N(N)) bus ();
  qdiv_seq #(.Q(Q), .N(N)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  // Scoreboard monitor: every o_done pops one expectation
  always @(negedge clk) begin
    if (rst_n && bus.o_done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done actual=%0h required=no_done", bus.o_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_result"}, bus.o_result, e.res);
        chk({e.nm, "_ovr"}, bus.o_ovr, e.ovr);
        chk({e.nm, "_dbz"}, bus.o_dbz, e.dbz);
        chk({e.nm, "_latency"}, cyc, e.cyc);
        chk({e.nm, "_busy_low"}, bus.o_busy, 1'b0);
      end
    end
  end
  task automatic issue(input logic [15:0] dd, input logic [15:0] dv, input logic [15:0] res,
                       input logic ovr, input logic dbz, input string nm);
    exp_t e;
    bus.i_dividend = dd;
    bus.i_divisor  = dv;
    bus.i_start    = 1'b1;
    @(posedge clk);
    #1;
    e.res = res; e.ovr = ovr; e.dbz = dbz; e.cyc = cyc + LAT; e.nm = nm;
    sb.push_back(e);
    bus.i_start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
  endtask
  logic [15:0] tv_dd [9] = '{16'h0300, 16'hFD00, 16'h0200, 16'h7F00, 16'h8000, 16'h0100, 16'hFF00, 16'h0000, 16'hFC00};
  logic [15:0] tv_dv [9] = '{16'h0200, 16'h0200, 16'h0300, 16'h0080, 16'h0100, 16'h0000, 16'h0000, 16'hFE00, 16'hFE00};
  logic [15:0] tv_rs [9] = '{16'h0180, 16'hFE80, R_2DIV3, 16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001, 16'h0000, 16'h0200};
  logic        tv_ov [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        tv_dz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    bus.i_start = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_done", bus.o_done, 1'b0);
    chk("rst_result", bus.o_result, 16'h0000);
    chk("rst_ovr", bus.o_ovr, 1'b0);
    chk("rst_dbz", bus.o_dbz, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      issue(tv_dd[i], tv_dv[i], tv_rs[i], tv_ov[i], tv_dz[i], $sformatf("vec%0d", i));
      wait_idle();
    end
    issue(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, "busy_first");
    repeat (5) @(negedge clk);
    chk("busy_high", bus.o_busy, 1'b1);
    bus.i_dividend = 16'h7F00;
    bus.i_divisor  = 16'h0000;
    bus.i_start    = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_idle();
    repeat (LAT + 5) @(negedge clk);
    chk("result_held", bus.o_result, 16'h0180);
    issue(16'h0200, 16'h0300, R_2DIV3, 1'b0, 1'b0, "b2b_first");
    repeat (LAT + 1) @(negedge clk);
    issue(16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, "b2b_second");
    wait_idle();
    issue(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, "aborted");
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", bus.o_busy, 1'b0);
    chk("async_rst_done", bus.o_done, 1'b0);
    chk("async_rst_result", bus.o_result, 16'h0000);
    chk("async_rst_ovr", bus.o_ovr, 1'b0);
    chk("async_rst_dbz", bus.o_dbz, 1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    issue(16'h0100, 16'h0400, 16'h0040, 1'b0, 1'b0, "after_rst");
    wait_idle();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/qdiv_seq.md
Name: qdiv_seq

Overview:
- Sequential signed fixed-point divider (QN.Q format, two's complement in/out), computing o_result = i_dividend / i_divisor.
- Inverse companion of the team's combinational fixed-point multiplier in the SOML decoder datapath.
- Restoring radix-2 algorithm, one quotient bit per clock; start/busy/done handshake to the decoder control FSM.

Parameters:
- Q, 8, number of fractional bits.
- N, 16, total word width including sign.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  request; sampled only when o_busy=0.
- i_dividend  input  N  dividend, two's complement QN.Q; captured on accepted start.
- i_divisor  input  N  divisor, two's complement QN.Q; captured on accepted start.
- o_busy  output  1  high while a division is in progress.
- o_done  output  1  one-cycle pulse; o_result and flags valid from this cycle.
- o_result  output  N  quotient, two's complement QN.Q; held until the next o_done.
- o_ovr  output  1  quotient magnitude exceeds 2^(N-1)-1, or divide by zero.
- o_dbz  output  1  divisor was zero.

Behaviour:
- Reset, asynchronous and active-low (i_rst_n=0):
  - State = IDLE.
  - o_busy, o_done, o_ovr and o_dbz = 0; o_result = 0.
  - All internal registers cleared.
  - Reset mid-operation aborts the division; no o_done is issued.
- States: IDLE, CALC, DONE.
- IDLE:
  - On i_start=1, capture operands and enter CALC.
  - Sign = XOR of the two MSBs.
  - Magnitudes = N-bit unsigned absolute values, so -2^(N-1) gives 2^(N-1).
  - Dividend register = |dividend| << Q (N+Q bits); remainder = 0; counter = N+Q.
  - dbz = (divisor == 0).
- CALC, each cycle:
  - Shift the remainder left, bringing in the next dividend MSB.
  - If remainder >= |divisor|: subtract it and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter; when it reaches 0, go to DONE.
  - The datapath runs for the full count even when dbz=1 (constant latency).
- DONE, one cycle:
  - o_done=1. o_result, o_ovr and o_dbz update in this cycle.
  - If dbz: o_dbz=1, o_ovr=1, magnitude saturates to 2^(N-1)-1.
  - Else if the N+Q-bit quotient is >= 2^(N-1): o_ovr=1, magnitude saturates to 2^(N-1)-1.
  - Otherwise magnitude = quotient[N-2:0], o_ovr=0.
  - o_result = sign ? -magnitude : magnitude. The result is never 0x8000.
  - Return to IDLE.
- o_busy=1 in CALC only; DONE and IDLE both have o_busy=0.
- i_start asserted during the DONE cycle is accepted (back-to-back operation): operands are captured and the next state is CALC.
- Latency: o_done is high in the cycle after edge t0+N+Q+1, where t0 is the accepting edge. With defaults this is 25 cycles.
- i_start while o_busy=1 is ignored; the captured operands are not disturbed.
- Quotient is truncated toward zero on the magnitude.
- Zero dividend gives result 0, with sign forced positive.

Optional Feature:
- Macro: QDIV_ROUND_EN.
- Defined:
  - CALC runs N+Q+1 iterations (one guard bit); latency becomes 26 cycles.
  - Magnitude = (quotient >> 1) + guard bit, i.e. round half away from zero.
  - The overflow/saturation check is applied after rounding.
- Undefined: truncation exactly as described in Behaviour.

Test Plan:
- 0x0300 / 0x0200 (3.0/2.0):
  - o_done exactly 25 cycles after acceptance.
  - o_result=0x0180; o_ovr=0; o_dbz=0.
- 0xFD00 / 0x0200 (-3.0/2.0) -> o_result=0xFE80.
- 0x0200 / 0x0300 (2/3) -> o_result=0x00AA; with QDIV_ROUND_EN: 0x00AB, latency 26.
- Overflow and divide by zero:
  - 0x7F00 / 0x0080 -> 0x7FFF, o_ovr=1.
  - 0x8000 / 0x0100 -> 0x8001, o_ovr=1.
  - 0x0100 / 0x0000 -> 0x7FFF, o_ovr=1, o_dbz=1.
  - 0xFF00 / 0x0000 -> 0x8001.
- Busy and back-to-back:
  - i_start with new operands 5 cycles into a division -> ignored; first result unchanged.
  - i_start in the DONE cycle -> second o_done follows 25 cycles later.
- Reset mid-operation:
  - i_rst_n pulsed low 10 cycles into CALC -> outputs immediately 0 (asynchronous); no o_done.
  - A subsequent division completes correctly.
